// File: rtl/updown_count_sequencer.sv
// Up/down counter sequencer: steps Count between latched bounds at a prescaled rate.
// Latency: start accept loads Count on the next edge; first step lands cfg_div+1 cycles later.
// Backpressure: start_ready is high only in IDLE; start_valid is ignored in every other state.
//
// Ports:
//   Clk, reset        rising-edge clock, synchronous active-low reset
//   start_valid/ready start command handshake, cfg_* sampled on accept
//   pause_req, abort  level hold request, abort pulse (abort wins)
//   Count, UpOrDown   current count value and direction (1 = up)
//   busy, done, wrap  RUN/HOLD indicator, end-of-one-shot pulse, wrap/turnaround pulse
//   cfg_err           pulse when a start with cfg_lo > cfg_hi is rejected
module updown_count_sequencer #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic             cfg_up,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             pause_req,
  input  logic             abort,
  output logic [WIDTH-1:0] Count,
  output logic             UpOrDown,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             cfg_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_DONE} state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             up_q, up_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic tick;
  logic at_end;

  assign tick   = (presc_q == div_q);
  // Endpoint depends on direction: the upper bound going up, the lower going down.
  assign at_end = up_q ? (count_q == hi_q) : (count_q == lo_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    up_d    = up_q;
    mode_d  = mode_q;
    div_d   = div_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          if (cfg_lo > cfg_hi) begin
            err_d = 1'b1;
          end else begin
            lo_d    = cfg_lo;
            hi_d    = cfg_hi;
            mode_d  = cfg_mode;
            div_d   = cfg_div;
            up_d    = cfg_up;
            count_d = cfg_up ? cfg_lo : cfg_hi;
            presc_d = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Priority: abort, then pause (freezes prescaler), then tick.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pause_req) begin
          state_d = ST_HOLD;
        end else if (!tick) begin
          presc_d = presc_q + DIV_ONE;
        end else begin
          presc_d = '0;
          if (!at_end) begin
            count_d = up_q ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
          end else begin
            case (mode_q)
              2'd1: begin
                count_d = up_q ? lo_q : hi_q;
                wrap_d  = 1'b1;
              end
              2'd2: begin
                // Turn around and step once the other way; a one-value range only flips.
                up_d   = ~up_q;
                wrap_d = 1'b1;
                if (lo_q != hi_q) begin
                  count_d = up_q ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
                end
              end
              default: state_d = ST_DONE;
            endcase
          end
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!pause_req) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      up_q    <= 1'b1;
      mode_q  <= 2'd0;
      div_q   <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      up_q    <= up_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done        = (state_q == ST_DONE);
  assign wrap        = wrap_q;
  assign cfg_err     = err_q;
  assign Count       = count_q;
  assign UpOrDown    = up_q;

endmodule
